shift_rows_axi: RTL and testbench
=================================

Name: shift_rows_axi

Overview:
- AXI4-Lite slave peripheral that performs the AES ShiftRows transform, or InvShiftRows when selected, on a 128-bit state.
- Sits directly upstream of the Mix_Columns peripheral in the software-sequenced AES round on the Zynq PS.
- Software writes four state columns, pulses START, polls DONE, then reads four result columns and forwards them to Mix_Columns.
- The transform is performed row-serially by an internal FSM on a snapshot of the input state.

Parameters:
C_S00_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S00_AXI_ADDR_WIDTH, 6, byte address width; 16 word slots.

Ports:
s00_axi_aclk  in  1  single clock, all logic rising-edge.
s00_axi_aresetn  in  1  asynchronous, active-low reset.
s00_axi_awaddr  in  6  write address.
s00_axi_awprot  in  3  ignored.
s00_axi_awvalid / s00_axi_awready  in / out  1  write-address handshake.
s00_axi_wdata  in  32  write data.
s00_axi_wstrb  in  4  byte strobes.
s00_axi_wvalid / s00_axi_wready  in / out  1  write-data handshake.
s00_axi_bresp  out  2  always OKAY (2'b00).
s00_axi_bvalid / s00_axi_bready  out / in  1  write-response handshake.
s00_axi_araddr  in  6  read address.
s00_axi_arprot  in  3  ignored.
s00_axi_arvalid / s00_axi_arready  in / out  1  read-address handshake.
s00_axi_rdata  out  32  read data.
s00_axi_rresp  out  2  always OKAY.
s00_axi_rvalid / s00_axi_rready  out / in  1  read-data handshake.
done_irq  out  1  level, equals STATUS.DONE AND CTRL.IE.

Behaviour:
- Reset (async assert, sync deassert on the clock edge):
  - all ready/valid outputs 0; rdata 0.
  - all registers 0; FSM in IDLE; done_irq 0.
- State packing: word c holds column c, with bits[31:24]=row0, [23:16]=row1, [15:8]=row2, [7:0]=row3.
- Transform:
  - fwd: out(r,c) = in(r,(c+r) mod 4).
  - inv: out(r,c) = in(r,(c-r) mod 4).
- Register map, word address = addr[5:2]:
  - 0x00-0x0C IN0..IN3: RW, wstrb honoured per byte.
  - 0x10-0x1C OUT0..OUT3: RO.
  - 0x20 CTRL: bit0 START (write-1 strobe, reads 0); bit1 INV (RW); bit2 IE (RW).
  - 0x24 STATUS: bit0 DONE (RO, sticky); bit1 BUSY (RO).
  - Other offsets read 0. Writes to RO or unmapped offsets are dropped but still get OKAY.
- Write channel:
  - awready and wready pulse high together for one cycle when awvalid and wvalid are both high and bvalid=0.
  - The register updates on that cycle.
  - bvalid rises the next cycle and holds until bready.
  - Only one write is outstanding; AW without W, or W without AW, waits.
- Read channel:
  - arready pulses one cycle when arvalid=1 and rvalid=0.
  - rvalid and rdata are registered the next cycle; they hold stable until rready.
- FSM states IDLE -> LOAD -> ROW (4 cycles, row counter 0..3) -> DONE -> IDLE.
  - Let T be the START write-handshake cycle. START is accepted only in IDLE.
  - T+1 LOAD: snapshot IN0..3 and CTRL.INV into the working state; BUSY=1; DONE cleared.
  - T+2..T+5 ROW: row k rotated into the result buffer, k = counter.
  - T+6 DONE: OUT0..3 updated atomically from the buffer; BUSY=0; STATUS.DONE=1; return to IDLE.
  - A STATUS read accepted at T+6 or later returns DONE=1.
- Boundary rules:
  - START while BUSY: ignored; the in-flight op is unaffected.
  - IN or INV writes while BUSY: stored, but they do not affect the in-flight op because it uses the snapshot.
  - OUT reads while BUSY return the previous result; they never return a partial result.
  - A START write with INV=1 in the same data word uses INV=1 for that operation.
  - DONE is cleared only by a new accepted START.
  - Simultaneous write and read handshakes are both served in the same cycle; the read returns the pre-write value.
  - Reset asserted mid-operation aborts it immediately: OUT=0, DONE=0, BUSY=0.

Test Plan:
- Forward transform: IN=0x00112233,0x44556677,0x8899AABB,0xCCDDEEFF; CTRL=0x1; poll DONE -> OUT0..3 = 0x0055AAFF, 0x4499EE33, 0x88DD2277, 0xCC1166BB; done_irq=0 (IE=0).
- Inverse transform: IN=0x0055AAFF,0x4499EE33,0x88DD2277,0xCC1166BB; CTRL=0x3 -> OUT = 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF.
- Latency: BUSY=1 from T+1 to T+5; DONE=1 at T+6. A second START at T+3 is ignored and DONE rises exactly once. CTRL=0x5 drives done_irq=1 at T+6.
- Snapshot isolation: write IN0=0xFFFFFFFF at T+3 of an op started with the first vector -> OUT matches the first vector's result. The next op uses 0xFFFFFFFF.
- Partial strobes: IN1=0 then write 0xAABBCCDD with wstrb=4'b0101 -> IN1 reads 0x00BB00DD. Write to 0x10 -> OUT0 unchanged, bresp=OKAY. Read of 0x3C -> 0.
- Reset mid-op: deassert s00_axi_aresetn at T+3 -> all outputs 0 immediately; after release STATUS=0 and OUT0..3=0. Back-pressure check: hold bready/rready low 5 cycles -> bvalid/rvalid and rdata stay stable.

Source files
------------

// File: rtl/shift_rows_axi.sv
// AES ShiftRows/InvShiftRows engine behind an AXI4-Lite register file; result lands in OUT0..3
// six cycles after the START write handshake, and each channel holds off its ready while a response is pending.
module shift_rows_axi #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 6
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic                              done_irq
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROW, S_DONE} state_t;

  localparam logic [3:0] A_CTRL = 4'h8;
  localparam logic [3:0] A_STAT = 4'h9;

  state_t           r_state;
  logic [1:0]       r_row;
  logic [3:0][31:0] r_in;
  logic [3:0][31:0] r_work;
  logic [3:0][31:0] r_buf;
  logic [3:0][31:0] r_out;
  logic             r_inv;
  logic             r_ie;
  logic             r_work_inv;
  logic             r_busy;
  logic             r_done;
  logic             r_awready;
  logic             r_bvalid;
  logic             r_arready;
  logic             r_rvalid;
  logic [31:0]      r_rdata;

  logic [3:0]       w_wr_idx;
  logic [3:0]       w_rd_idx;
  logic             w_wr_hs;
  logic             w_rd_hs;
  logic             w_start;
  logic [31:0]      w_rd_dat;
  logic [3:0][31:0] w_buf_next;
  logic [1:0]       w_src;
  logic [4:0]       w_lsb;
  logic             w_unused;

  assign w_wr_idx = s00_axi_awaddr[5:2];
  assign w_rd_idx = s00_axi_araddr[5:2];
  assign w_wr_hs  = r_awready & s00_axi_awvalid & s00_axi_wvalid;
  assign w_rd_hs  = r_arready & s00_axi_arvalid;
  assign w_start  = w_wr_hs & (w_wr_idx == A_CTRL) & s00_axi_wstrb[0] & s00_axi_wdata[0];
  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Write channel and software-visible IN/CTRL registers
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_in      <= '0;
      r_inv     <= 1'b0;
      r_ie      <= 1'b0;
    end else begin
      r_awready <= ~r_awready & s00_axi_awvalid & s00_axi_wvalid & ~r_bvalid;
      if (w_wr_hs) r_bvalid <= 1'b1;
      else if (s00_axi_bready) r_bvalid <= 1'b0;
      if (w_wr_hs) begin
        if (w_wr_idx < 4'd4) begin
          for (int b = 0; b < 4; b++)
            if (s00_axi_wstrb[b]) r_in[w_wr_idx[1:0]][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
        end else if (w_wr_idx == A_CTRL && s00_axi_wstrb[0]) begin
          r_inv <= s00_axi_wdata[1];
          r_ie  <= s00_axi_wdata[2];
        end
      end
    end
  end

  always_comb begin
    w_rd_dat = '0;
    case (w_rd_idx)
      4'h0, 4'h1, 4'h2, 4'h3: w_rd_dat = r_in[w_rd_idx[1:0]];
      4'h4, 4'h5, 4'h6, 4'h7: w_rd_dat = r_out[w_rd_idx[1:0]];
      A_CTRL:                 w_rd_dat = {29'd0, r_ie, r_inv, 1'b0};
      A_STAT:                 w_rd_dat = {30'd0, r_busy, r_done};
      default:                w_rd_dat = '0;
    endcase
  end

  // Read data is captured at the handshake edge, so a same-cycle write is not yet visible
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= ~r_arready & s00_axi_arvalid & ~r_rvalid;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_dat;
      end else if (s00_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Row r sits at byte lane 3-r of every column word
  assign w_lsb = {~r_row, 3'b000};

  always_comb begin
    w_buf_next = r_buf;
    w_src      = '0;
    for (int c = 0; c < 4; c++) begin
      w_src = r_work_inv ? (2'(c) - r_row) : (2'(c) + r_row);
      w_buf_next[c][w_lsb +: 8] = r_work[w_src][w_lsb +: 8];
    end
  end

  // The last row is folded straight into OUT so software never sees a partial result
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_work     <= '0;
      r_work_inv <= 1'b0;
      r_buf      <= '0;
      r_out      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_LOAD: begin
          r_work     <= r_in;
          r_work_inv <= r_inv;
          r_row      <= '0;
          r_state    <= S_ROW;
        end
        S_ROW: begin
          r_buf <= w_buf_next;
          r_row <= r_row + 2'd1;
          if (r_row == 2'd3) begin
            r_out   <= w_buf_next;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s00_axi_awready = r_awready;
  assign s00_axi_wready  = r_awready;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = 2'b00;
  assign s00_axi_rvalid  = r_rvalid;
  assign done_irq        = r_done & r_ie;

endmodule

// File: tb/tb_shift_rows_axi.sv
// Bench for shift_rows_axi: register-map model plus an array-based ShiftRows reference,
// with read expectations queued at issue time and checked by an independent monitor.
`timescale 1ns/1ps
module tb_shift_rows_axi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [5:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        done_irq;

  always #5 clk = ~clk;

  shift_rows_axi dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .done_irq(done_irq)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endfunction

  function automatic void fail_note(input string nm, input string why);
    n_total++;
    $display("FAIL %s: %s", nm, why);
  endfunction

  // Reference: out(r,c) = in(r,(c+r) mod 4), or (c-r) mod 4 for the inverse
  function automatic logic [31:0] ref_col(input logic [31:0] st [4], input int c, input bit inv);
    logic [31:0] w;
    int src;
    w = '0;
    for (int r = 0; r < 4; r++) begin
      src = inv ? (c - r + 4) % 4 : (c + r) % 4;
      w[31-8*r -: 8] = st[src][31-8*r -: 8];
    end
    return w;
  endfunction

  logic [31:0] m_in   [4];
  logic [31:0] m_out  [4];
  logic [31:0] m_pend [4];
  bit          m_inv = 1'b0;
  bit          m_ie  = 1'b0;

  logic [31:0] exp_q [$];
  string       nm_q  [$];

  always @(negedge clk) begin
    if (rst_n && rvalid && rready) begin
      if (exp_q.size() == 0) fail_note("read_monitor", $sformatf("unexpected read data 0x%08h", rdata));
      else chk(nm_q.pop_front(), rdata, exp_q.pop_front());
    end
    if (rst_n && bvalid && bready) chk("bresp", 32'(bresp), 32'd0);
  end

  int   irq_rises = 0;
  int   irq_rise_cyc = 0;
  logic prev_irq = 1'b0;
  always @(negedge clk) begin
    if (done_irq && !prev_irq) begin
      irq_rises++;
      irq_rise_cyc = cyc;
    end
    prev_irq = done_irq;
  end

  int last_wr_cyc = 0;
  int op_cyc = 0;

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF, input int hold = 0);
    int   n;
    logic ok;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = (hold == 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(awready && wready) && n < 40);
    if (!(awready && wready)) begin
      fail_note("write_addr_data", "no awready/wready within 40 cycles");
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
      return;
    end
    @(posedge clk); #1;
    last_wr_cyc = cyc; awvalid = 1'b0; wvalid = 1'b0;
    if (hold > 0) begin
      ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!bvalid || bresp !== 2'b00) ok = 1'b0;
      end
      chk("bvalid_hold", 32'(ok), 32'd1);
      @(posedge clk); #1;
      bready = 1'b1;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!(bvalid && bready) && n < 40);
    if (!(bvalid && bready)) fail_note("write_resp", "no bvalid within 40 cycles");
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] e, input string nm, input int hold = 0);
    int          n;
    logic        ok;
    logic [31:0] d0;
    exp_q.push_back(e); nm_q.push_back(nm);
    araddr = a; arvalid = 1'b1; rready = (hold == 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 40);
    if (!arready) begin
      fail_note(nm, "no arready within 40 cycles");
      arvalid = 1'b0; rready = 1'b1;
      void'(exp_q.pop_back()); void'(nm_q.pop_back());
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (hold > 0) begin
      @(negedge clk);
      d0 = rdata; ok = rvalid;
      for (int i = 1; i < hold; i++) begin
        @(negedge clk);
        if (!rvalid || rdata !== d0) ok = 1'b0;
      end
      chk({nm, "_hold"}, 32'(ok), 32'd1);
      @(posedge clk); #1;
      rready = 1'b1;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!(rvalid && rready) && n < 40);
    if (!(rvalid && rready)) fail_note(nm, "no rvalid within 40 cycles");
    @(posedge clk); #1;
  endtask

  task automatic wr_in(input int i, input logic [31:0] d, input logic [3:0] s = 4'hF, input int hold = 0);
    for (int b = 0; b < 4; b++)
      if (s[b]) m_in[i][8*b +: 8] = d[8*b +: 8];
    wr(6'(4*i), d, s, hold);
  endtask

  task automatic start_op(input bit inv, input bit ie);
    for (int c = 0; c < 4; c++) m_pend[c] = ref_col(m_in, c, inv);
    m_inv = inv; m_ie = ie;
    wr(6'h20, {29'd0, ie, inv, 1'b1});
    op_cyc = last_wr_cyc;
  endtask

  task automatic finish_op();
    repeat (10) @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) m_out[c] = m_pend[c];
  endtask

  task automatic check_out(input string tag);
    for (int c = 0; c < 4; c++) rd(6'(16 + 4*c), m_out[c], $sformatf("%s_out%0d", tag, c));
  endtask

  task automatic rand_op(input int k);
    bit inv;
    bit ie;
    inv = 1'($urandom_range(0, 1));
    ie  = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) wr_in(i, $urandom, (k < 3) ? 4'hF : 4'($urandom_range(1, 15)));
    start_op(inv, ie);
    finish_op();
    check_out($sformatf("rnd%0d", k));
    chk($sformatf("rnd%0d_irq", k), 32'(done_irq), 32'(ie));
  endtask

  initial begin
    int          h;
    logic [31:0] old;
    for (int i = 0; i < 4; i++) begin m_in[i] = '0; m_out[i] = '0; end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", 32'(done_irq), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    rd(6'h24, 32'h0, "rst_status");
    rd(6'h20, 32'h0, "rst_ctrl");
    rd(6'h10, 32'h0, "rst_out0");

    // Forward transform on the reference vector
    wr_in(0, 32'h00112233); wr_in(1, 32'h44556677); wr_in(2, 32'h8899AABB); wr_in(3, 32'hCCDDEEFF);
    start_op(1'b0, 1'b0);
    finish_op();
    check_out("fwd");
    rd(6'h24, 32'h1, "fwd_status");
    chk("fwd_irq", 32'(done_irq), 32'd0);

    // Inverse of the forward result should restore the original state
    for (int i = 0; i < 4; i++) wr_in(i, m_out[i]);
    start_op(1'b1, 1'b0);
    finish_op();
    check_out("inv");

    // Latency, BUSY window, ignored second START, single interrupt edge
    irq_rises = 0;
    start_op(1'b0, 1'b1);
    h = op_cyc;
    fork
      wr(6'h20, 32'h5);
      rd(6'h24, 32'h2, "status_busy_T3");
    join
    rd(6'h24, 32'h1, "status_done_T6");
    finish_op();
    chk("irq_rises", 32'(irq_rises), 32'd1);
    chk("irq_latency", 32'(irq_rise_cyc - h), 32'd5);
    chk("lat_irq_level", 32'(done_irq), 32'd1);
    check_out("lat");
    rd(6'h20, {29'd0, m_ie, m_inv, 1'b0}, "ctrl_readback");

    // Snapshot isolation: IN0 rewritten and OUT0 read while the op is in flight
    wr_in(0, 32'h00112233); wr_in(1, 32'h44556677); wr_in(2, 32'h8899AABB); wr_in(3, 32'hCCDDEEFF);
    start_op(1'b0, 1'b0);
    old = m_out[0];
    fork
      wr_in(0, 32'hFFFFFFFF);
      rd(6'h10, old, "busy_out0_prev");
    join
    finish_op();
    check_out("snap");
    start_op(1'b0, 1'b0);
    finish_op();
    check_out("snap_next");

    // Byte strobes, dropped RO write, unmapped read
    wr_in(1, 32'h0);
    wr_in(1, 32'hAABBCCDD, 4'b0101);
    rd(6'h04, m_in[1], "strobe_in1");
    wr(6'h10, 32'h12345678);
    rd(6'h10, m_out[0], "ro_out0_kept");
    rd(6'h3C, 32'h0, "unmapped_3c");

    // Same-cycle write and read of one register
    old = m_in[2];
    fork
      wr_in(2, 32'h13579BDF);
      rd(6'h08, old, "rw_same_cycle");
    join
    rd(6'h08, m_in[2], "rw_after");

    // Back-pressure on both response channels
    wr_in(3, 32'hCAFEF00D, 4'hF, 5);
    rd(6'h0C, m_in[3], "rd_backpressure", 5);

    for (int k = 0; k < 6; k++) rand_op(k);

    // Reset during an operation
    start_op(1'b0, 1'b1);
    finish_op();
    chk("pre_rst_irq", 32'(done_irq), 32'd1);
    rd(6'h10, m_out[0], "pre_rst_out0");
    start_op(1'b1, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_awready", 32'(awready), 32'd0);
    chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_irq", 32'(done_irq), 32'd0);
    for (int i = 0; i < 4; i++) begin m_in[i] = '0; m_out[i] = '0; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(6'h24, 32'h0, "post_rst_status");
    check_out("post_rst");
    rd(6'h20, 32'h0, "post_rst_ctrl");
    rd(6'h00, m_in[0], "post_rst_in0");
    repeat (10) @(posedge clk);
    #1;
    rd(6'h24, 32'h0, "post_rst_status_late");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
